// File: rtl/message_scroller_pkg.sv
// Shared widths and types for the message scroller: 16 entries of 4-bit
// character codes addressed by a 4-bit wrapping pointer.
package message_scroller_pkg;
   localparam int CHAR_W  = 4;
   localparam int MSG_LEN = 16;
   localparam int PTR_W   = 4;

   typedef logic [CHAR_W-1:0] char_t;
   typedef logic [PTR_W-1:0]  ptr_t;
endpackage

// File: rtl/message_store.sv
// 16x4 message register file: one write port, four combinational read ports
// at ptr+0..ptr+3 (indices wrap modulo 16). Reset loads the identity message.
module message_store
   import message_scroller_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [PTR_W-1:0]  wr_addr,
   input  logic [CHAR_W-1:0] wr_data,
   input  logic [PTR_W-1:0]  ptr,
   output logic [CHAR_W-1:0] rd0,
   output logic [CHAR_W-1:0] rd1,
   output logic [CHAR_W-1:0] rd2,
   output logic [CHAR_W-1:0] rd3
);

   char_t mem [MSG_LEN];
   ptr_t  ptr1;
   ptr_t  ptr2;
   ptr_t  ptr3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MSG_LEN; i++) mem[i] <= char_t'(i);
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // 4-bit sums wrap naturally, so ptr = 14 reads 14, 15, 0, 1.
   assign ptr1 = ptr + PTR_W'(1);
   assign ptr2 = ptr + PTR_W'(2);
   assign ptr3 = ptr + PTR_W'(3);

   assign rd0 = mem[ptr];
   assign rd1 = mem[ptr1];
   assign rd2 = mem[ptr2];
   assign rd3 = mem[ptr3];

endmodule

// File: rtl/message_scroller.sv
// Sliding 4-character window over a writable 16-entry message, stepping one
// position every SCROLL_PERIOD unpaused clocks. All outputs are registered.
module message_scroller
   import message_scroller_pkg::*;
#(
   parameter int SCROLL_PERIOD = 3125000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pause,
   input  logic              dir,
   input  logic              wr_en,
   input  logic [PTR_W-1:0]  wr_addr,
   input  logic [CHAR_W-1:0] wr_data,
   output logic [CHAR_W-1:0] char3,
   output logic [CHAR_W-1:0] char2,
   output logic [CHAR_W-1:0] char1,
   output logic [CHAR_W-1:0] char0,
   output logic              step
);

   localparam int               CNT_W    = $clog2(SCROLL_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_PERIOD - 1);

   logic [PTR_W-1:0]  ptr;
   logic [CNT_W-1:0]  cnt;
   logic              moved;
   logic              at_last;
   logic [CHAR_W-1:0] rd0;
   logic [CHAR_W-1:0] rd1;
   logic [CHAR_W-1:0] rd2;
   logic [CHAR_W-1:0] rd3;

   message_store u_store (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .ptr     (ptr),
      .rd0     (rd0),
      .rd1     (rd1),
      .rd2     (rd2),
      .rd3     (rd3)
   );

   assign at_last = (cnt == CNT_LAST);

   // The window register samples ptr/mem one clock after they change, and
   // moved delays the step pulse by the same clock so both appear together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         cnt   <= '0;
         moved <= 1'b0;
         step  <= 1'b0;
         char3 <= char_t'(0);
         char2 <= char_t'(1);
         char1 <= char_t'(2);
         char0 <= char_t'(3);
      end else begin
         moved <= !pause && at_last;
         step  <= moved;
         char3 <= rd0;
         char2 <= rd1;
         char1 <= rd2;
         char0 <= rd3;
         if (!pause) begin
            if (at_last) begin
               cnt <= '0;
               ptr <= dir ? ptr - PTR_W'(1) : ptr + PTR_W'(1);
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_message_scroller.sv
// Directed bench for message_scroller with SCROLL_PERIOD = 4: a message/pointer
// model predicts each window, queued when a step is provoked and checked on step.
module tb_message_scroller;

   localparam int P = 4;

   logic       clk;
   logic       rst;
   logic       pause;
   logic       dir;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [3:0] wr_data;
   logic [3:0] char3;
   logic [3:0] char2;
   logic [3:0] char1;
   logic [3:0] char0;
   logic       step;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic [3:0]  m_mem[16];
   logic [3:0]  m_ptr;

   message_scroller #(.SCROLL_PERIOD(P)) dut (
      .clk     (clk),
      .rst     (rst),
      .pause   (pause),
      .dir     (dir),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .char3   (char3),
      .char2   (char2),
      .char1   (char1),
      .char0   (char0),
      .step    (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] win(input logic [3:0] p);
      logic [3:0] p1, p2, p3;
      p1 = p + 4'd1;
      p2 = p + 4'd2;
      p3 = p + 4'd3;
      return {m_mem[p], m_mem[p1], m_mem[p2], m_mem[p3]};
   endfunction

   function automatic logic [15:0] chars();
      return {char3, char2, char1, char0};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 4'(i);
      m_ptr = 4'd0;
   endtask

   task automatic write_cycle(input logic [3:0] a, input logic [3:0] d);
      m_mem[a] = d;
      wr_en    = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      tick();
      wr_en    = 1'b0;
   endtask

   // Waits (bounded) for the step pulse, checks its distance and the window.
   task automatic wait_step(input int exp_n, input string tag);
      int          n;
      logic [15:0] e;
      n = 0;
      do begin
         tick();
         n++;
      end while (step !== 1'b1 && n < exp_n + 20);
      chk({tag, "_interval"}, n, exp_n);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_window"}, chars(), e);
      end
   endtask

   task automatic advance(input int exp_n, input string tag);
      m_ptr = dir ? m_ptr - 4'd1 : m_ptr + 4'd1;
      exp_q.push_back(win(m_ptr));
      wait_step(exp_n, tag);
   endtask

   initial begin
      rst = 1'b1; pause = 1'b0; dir = 1'b0;
      wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_window", chars(), 16'h0123);
      chk("reset_step", step, 1'b0);

      // First step: ptr moves on the 4th edge, window/step on the 5th.
      @(negedge clk);
      rst = 1'b0;
      advance(P + 1, "first_step");
      chk("first_window", chars(), 16'h1234);

      for (int i = 0; i < 13; i++) advance(P, "scroll");
      chk("wrap_window", chars(), 16'hEF01);
      advance(P, "scroll");
      advance(P, "scroll");
      chk("full_cycle_window", chars(), 16'h0123);

      dir = 1'b1;
      advance(P, "dir_right");
      chk("dir_right_window", chars(), 16'hF012);
      dir = 1'b0;
      for (int i = 0; i < 3; i++) advance(P, "scroll");
      chk("ptr2_window", chars(), 16'h2345);

      // Write during scroll, then a write coincident with the ptr update.
      write_cycle(4'd4, 4'd9);
      tick();
      chk("wr_char1", char1, 4'd9);
      m_ptr = 4'd3;
      m_mem[5] = 4'd7;
      exp_q.push_back(win(m_ptr));
      write_cycle(4'd5, 4'd7);
      wait_step(1, "wr_coincident");
      chk("wr_coincident_char2", char2, 4'd9);
      chk("wr_coincident_char1", char1, 4'd7);

      // Pause at cnt = 2 for 10 clocks, with a write inside the pause.
      tick();
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) write_cycle(4'd6, 4'hA);
         else tick();
         if (i == 4) chk("pause_wr_char0", char0, 4'hA);
      end
      chk("pause_step", step, 1'b0);
      chk("pause_hold_char3", char3, 4'd3);
      pause = 1'b0;
      advance(3, "after_pause");
      chk("after_pause_window", chars(), 16'h97A7);

      for (int i = 0; i < 3; i++) advance(P, "scroll");
      chk("ptr7_window", chars(), win(4'd7));

      // Asynchronous reset between edges with a write pending.
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'd5;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_window", chars(), 16'h0123);
      chk("async_rst_step", step, 1'b0);
      wr_en = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      advance(P + 1, "post_rst_step");
      dir = 1'b1;
      advance(P, "post_rst_back");
      chk("post_rst_mem0", char3, 4'd0);

      // Back-to-back writes of the reversed message while paused at ptr 0.
      pause = 1'b1;
      for (int i = 0; i < 16; i++) write_cycle(4'(i), 4'(15 - i));
      tick();
      chk("rev_window", chars(), 16'hFEDC);
      chk("rev_step", step, 1'b0);
      pause = 1'b0;
      dir = 1'b0;
      advance(P, "rev_step");
      chk("rev_next_window", chars(), 16'hEDCB);

      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
